// File: rtl/cluster_noc_map_ctrl.sv
// Cluster NoC address-map controller: shadow map written over the config port,
// swapped into the active map after gating and draining outstanding AW/AR traffic.
//
// state | meaning
// IDLE  | config writes and commit requests accepted, blocks only on full counters
// DRAIN | new AW/AR gated, waiting for both outstanding counters to reach zero
// APPLY | shadow map copied into active map, done pulse issued next cycle
module cluster_noc_map_ctrl #(
  parameter int NumClusters    = 4,
  parameter int AddrWidth      = 32,
  parameter int MaxOutstanding = 8,
  localparam int CntWidth      = $clog2(MaxOutstanding + 1),
  localparam int IdxWidth      = (NumClusters > 1) ? $clog2(NumClusters) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             cfg_valid_i,
  output logic                             cfg_ready_o,
  input  logic [IdxWidth-1:0]              cfg_idx_i,
  input  logic                             cfg_sel_end_i,
  input  logic [AddrWidth-1:0]             cfg_addr_i,
  input  logic                             commit_valid_i,
  output logic                             commit_ready_o,
  output logic                             commit_done_o,
  input  logic                             aw_hs_i,
  input  logic                             ar_hs_i,
  input  logic                             b_hs_i,
  input  logic                             r_last_hs_i,
  output logic                             aw_block_o,
  output logic                             ar_block_o,
  output logic [NumClusters*AddrWidth-1:0] cl_start_addr_o,
  output logic [NumClusters*AddrWidth-1:0] cl_end_addr_o,
  output logic [CntWidth-1:0]              wr_cnt_o,
  output logic [CntWidth-1:0]              rd_cnt_o,
  output logic                             err_o
);

  typedef enum logic [1:0] {IDLE, DRAIN, APPLY} state_e;

  localparam logic [CntWidth-1:0] CntMax   = CntWidth'(MaxOutstanding);
  localparam logic [IdxWidth:0]   NumClW   = (IdxWidth + 1)'(NumClusters);

  state_e               state;
  logic [AddrWidth-1:0] shadow_start [NumClusters];
  logic [AddrWidth-1:0] shadow_end   [NumClusters];
  logic [AddrWidth-1:0] active_start [NumClusters];
  logic [AddrWidth-1:0] active_end   [NumClusters];
  logic [CntWidth-1:0]  wr_cnt, rd_cnt, wr_nxt, rd_nxt;
  logic                 wr_err, rd_err;
  logic                 commit_done, err;
  logic                 cfg_hs, cfg_idx_ok;

  assign cfg_ready_o    = (state == IDLE);
  assign commit_ready_o = (state == IDLE);
  assign cfg_hs         = cfg_valid_i && cfg_ready_o;
  assign cfg_idx_ok     = {1'b0, cfg_idx_i} < NumClW;

  // Blocks come straight from registered state so an in-flight handshake is never cut.
  assign aw_block_o    = (state != IDLE) || (wr_cnt == CntMax);
  assign ar_block_o    = (state != IDLE) || (rd_cnt == CntMax);
  assign commit_done_o = commit_done;
  assign err_o         = err;
  assign wr_cnt_o      = wr_cnt;
  assign rd_cnt_o      = rd_cnt;

  for (genvar g = 0; g < NumClusters; g++) begin : g_pack
    assign cl_start_addr_o[g*AddrWidth +: AddrWidth] = active_start[g];
    assign cl_end_addr_o[g*AddrWidth +: AddrWidth]   = active_end[g];
  end

  // Simultaneous increment and decrement cancel; over/underflow saturates and flags.
  always_comb begin
    wr_nxt = wr_cnt;
    wr_err = 1'b0;
    if (aw_hs_i && !b_hs_i) begin
      if (wr_cnt == CntMax) wr_err = 1'b1;
      else                  wr_nxt = wr_cnt + CntWidth'(1);
    end else if (!aw_hs_i && b_hs_i) begin
      if (wr_cnt == '0) wr_err = 1'b1;
      else              wr_nxt = wr_cnt - CntWidth'(1);
    end
    rd_nxt = rd_cnt;
    rd_err = 1'b0;
    if (ar_hs_i && !r_last_hs_i) begin
      if (rd_cnt == CntMax) rd_err = 1'b1;
      else                  rd_nxt = rd_cnt + CntWidth'(1);
    end else if (!ar_hs_i && r_last_hs_i) begin
      if (rd_cnt == '0) rd_err = 1'b1;
      else              rd_nxt = rd_cnt - CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= IDLE;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      commit_done <= 1'b0;
      err         <= 1'b0;
      for (int i = 0; i < NumClusters; i++) begin
        shadow_start[i] <= '0;
        shadow_end[i]   <= '0;
        active_start[i] <= '0;
        active_end[i]   <= '0;
      end
    end else begin
      wr_cnt      <= wr_nxt;
      rd_cnt      <= rd_nxt;
      commit_done <= 1'b0;
      if (wr_err || rd_err || (cfg_hs && !cfg_idx_ok)) err <= 1'b1;
      for (int i = 0; i < NumClusters; i++) begin
        if (cfg_hs && cfg_idx_i == IdxWidth'(i)) begin
          if (cfg_sel_end_i) shadow_end[i]   <= cfg_addr_i;
          else               shadow_start[i] <= cfg_addr_i;
        end
      end
      case (state)
        IDLE:  if (commit_valid_i) state <= DRAIN;
        DRAIN: if (wr_cnt == '0 && rd_cnt == '0) state <= APPLY;
        APPLY: begin
          for (int i = 0; i < NumClusters; i++) begin
            active_start[i] <= shadow_start[i];
            active_end[i]   <= shadow_end[i];
          end
          commit_done <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cluster_noc_map_ctrl.sv
// Self-checking bench for cluster_noc_map_ctrl: scoreboard of committed maps plus
// direct counter/block/error checks; a second 3-cluster instance covers bad indices.
module tb_cluster_noc_map_ctrl;

  localparam int NC = 4;
  localparam int AW = 32;
  localparam int CW = 4;

  typedef struct {
    logic [127:0] s;
    logic [127:0] e;
  } map_t;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic cfg_valid, cfg_sel_end, commit_valid;
  logic [1:0] cfg_idx;
  logic [AW-1:0] cfg_addr;
  logic aw_hs, ar_hs, b_hs, r_last_hs;
  logic cfg_ready, commit_ready, commit_done, aw_block, ar_block, err;
  logic [NC*AW-1:0] cl_start, cl_end;
  logic [CW-1:0] wr_cnt, rd_cnt;

  logic n3_cfg_valid, n3_cfg_sel_end, n3_commit_valid;
  logic [1:0] n3_cfg_idx;
  logic [AW-1:0] n3_cfg_addr;
  logic n3_cfg_ready, n3_commit_ready, n3_done, n3_aw_block, n3_ar_block, n3_err;
  logic [3*AW-1:0] n3_start, n3_end;
  logic [CW-1:0] n3_wr_cnt, n3_rd_cnt;

  logic [AW-1:0] m_start [NC];
  logic [AW-1:0] m_end [NC];
  logic [127:0] act_s, act_e;
  map_t sb_q[$];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  cluster_noc_map_ctrl #(.NumClusters(4), .AddrWidth(32), .MaxOutstanding(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_idx_i(cfg_idx),
    .cfg_sel_end_i(cfg_sel_end), .cfg_addr_i(cfg_addr),
    .commit_valid_i(commit_valid), .commit_ready_o(commit_ready), .commit_done_o(commit_done),
    .aw_hs_i(aw_hs), .ar_hs_i(ar_hs), .b_hs_i(b_hs), .r_last_hs_i(r_last_hs),
    .aw_block_o(aw_block), .ar_block_o(ar_block),
    .cl_start_addr_o(cl_start), .cl_end_addr_o(cl_end),
    .wr_cnt_o(wr_cnt), .rd_cnt_o(rd_cnt), .err_o(err)
  );

  cluster_noc_map_ctrl #(.NumClusters(3), .AddrWidth(32), .MaxOutstanding(8)) dut3 (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_valid_i(n3_cfg_valid), .cfg_ready_o(n3_cfg_ready), .cfg_idx_i(n3_cfg_idx),
    .cfg_sel_end_i(n3_cfg_sel_end), .cfg_addr_i(n3_cfg_addr),
    .commit_valid_i(n3_commit_valid), .commit_ready_o(n3_commit_ready), .commit_done_o(n3_done),
    .aw_hs_i(1'b0), .ar_hs_i(1'b0), .b_hs_i(1'b0), .r_last_hs_i(1'b0),
    .aw_block_o(n3_aw_block), .ar_block_o(n3_ar_block),
    .cl_start_addr_o(n3_start), .cl_end_addr_o(n3_end),
    .wr_cnt_o(n3_wr_cnt), .rd_cnt_o(n3_rd_cnt), .err_o(n3_err)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] flat(input logic [AW-1:0] a [NC]);
    logic [127:0] f = '0;
    for (int i = 0; i < NC; i++) f[i*AW +: AW] = a[i];
    return f;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NC; i++) begin
      m_start[i] = '0;
      m_end[i]   = '0;
    end
    act_s = '0;
    act_e = '0;
    sb_q.delete();
  endtask

  task automatic cfg_write(input int idx, input logic sel, input logic [AW-1:0] addr);
    cfg_valid = 1'b1; cfg_idx = 2'(idx); cfg_sel_end = sel; cfg_addr = addr;
    chk("cfg_ready", cfg_ready, 1'b1);
    tick();
    cfg_valid = 1'b0;
    if (sel) m_end[idx] = addr;
    else     m_start[idx] = addr;
  endtask

  // Commit issued now; b_hs driven in cycles T+b_start .. T+b_start+n_b-1.
  task automatic run_commit(input int b_start, input int n_b, input int exp_lat);
    map_t m;
    bit seen = 1'b0;
    m.s = flat(m_start);
    m.e = flat(m_end);
    sb_q.push_back(m);
    chk("commit_ready", commit_ready, 1'b1);
    commit_valid = 1'b1;
    tick();
    commit_valid = 1'b0;
    cfg_valid = 1'b0;
    for (int c = 1; c <= 30 && !seen; c++) begin
      if (commit_done) begin
        seen = 1'b1;
        chk("commit_latency", c, exp_lat);
        if (sb_q.size() == 0) chk("sb_empty", 1'b1, 1'b0);
        else begin
          m = sb_q.pop_front();
          chk("map_start", cl_start, m.s);
          chk("map_end", cl_end, m.e);
          act_s = m.s;
          act_e = m.e;
        end
        chk("wr_cnt_after", wr_cnt, 0);
        chk("aw_release", aw_block, 1'b0);
        chk("ar_release", ar_block, 1'b0);
      end else begin
        chk("map_hold_start", cl_start, act_s);
        chk("map_hold_end", cl_end, act_e);
        chk("aw_block_drain", aw_block, 1'b1);
        chk("ar_block_drain", ar_block, 1'b1);
        chk("cfg_ready_drain", cfg_ready, 1'b0);
      end
      b_hs = (c >= b_start && c < b_start + n_b);
      if (!seen) tick();
    end
    b_hs = 1'b0;
    if (!seen) chk("commit_timeout", 1'b0, 1'b1);
    tick();
    chk("done_pulse", commit_done, 1'b0);
  endtask

  initial begin
    rst_ni = 1'b0;
    cfg_valid = 0; cfg_sel_end = 0; cfg_idx = 0; cfg_addr = 0; commit_valid = 0;
    aw_hs = 0; ar_hs = 0; b_hs = 0; r_last_hs = 0;
    n3_cfg_valid = 0; n3_cfg_sel_end = 0; n3_cfg_idx = 0; n3_cfg_addr = 0; n3_commit_valid = 0;
    model_clear();
    tick(); tick();
    rst_ni = 1'b1;
    chk("rst_wr_cnt", wr_cnt, 0);
    chk("rst_rd_cnt", rd_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_done", commit_done, 0);
    chk("rst_blocks", {aw_block, ar_block}, 2'b00);
    chk("rst_map", {cl_start, cl_end}, 0);

    // Plain commit with no traffic
    cfg_write(1, 1'b0, 32'h1000);
    cfg_write(1, 1'b1, 32'h2000);
    tick();
    chk("shadow_not_active", cl_start, 0);
    run_commit(0, 0, 3);
    chk("slice1_start", cl_start[1*AW +: AW], 32'h1000);
    chk("slice1_end", cl_end[1*AW +: AW], 32'h2000);

    // Three writes outstanding; cfg write coincident with commit is included
    aw_hs = 1'b1;
    repeat (3) tick();
    aw_hs = 1'b0;
    chk("wr_cnt_3", wr_cnt, 3);
    cfg_valid = 1'b1; cfg_idx = 2'd2; cfg_sel_end = 1'b0; cfg_addr = 32'h3000;
    m_start[2] = 32'h3000;
    run_commit(4, 3, 9);
    chk("slice2_start", cl_start[2*AW +: AW], 32'h3000);

    // Read backpressure at the limit
    ar_hs = 1'b1;
    repeat (8) tick();
    ar_hs = 1'b0;
    chk("rd_cnt_8", rd_cnt, 8);
    chk("ar_block_full", ar_block, 1'b1);
    chk("aw_block_free", aw_block, 1'b0);
    r_last_hs = 1'b1;
    tick();
    r_last_hs = 1'b0;
    chk("rd_cnt_7", rd_cnt, 7);
    chk("ar_block_released", ar_block, 1'b0);
    r_last_hs = 1'b1;
    repeat (7) tick();
    r_last_hs = 1'b0;
    chk("rd_cnt_0", rd_cnt, 0);
    chk("err_clean", err, 1'b0);

    // Net-zero update and underflow
    aw_hs = 1'b1;
    repeat (2) tick();
    b_hs = 1'b1;
    tick();
    aw_hs = 1'b0;
    chk("wr_cnt_net0", wr_cnt, 2);
    repeat (2) tick();
    chk("wr_cnt_drained", wr_cnt, 0);
    chk("err_before_uflow", err, 1'b0);
    tick();
    b_hs = 1'b0;
    chk("wr_cnt_uflow", wr_cnt, 0);
    chk("err_uflow", err, 1'b1);
    repeat (3) tick();
    chk("err_sticky", err, 1'b1);

    // Reset while draining
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    model_clear();
    chk("err_reset", err, 1'b0);
    aw_hs = 1'b1;
    repeat (2) tick();
    aw_hs = 1'b0;
    cfg_write(0, 1'b0, 32'hABCD);
    commit_valid = 1'b1;
    tick();
    commit_valid = 1'b0;
    tick();
    chk("drain_block", aw_block, 1'b1);
    chk("drain_wr_cnt", wr_cnt, 2);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    model_clear();
    chk("rstd_idle", {cfg_ready, commit_ready}, 2'b11);
    chk("rstd_cnts", {wr_cnt, rd_cnt}, 0);
    chk("rstd_map", {cl_start, cl_end}, 0);
    chk("rstd_blocks", {aw_block, ar_block}, 2'b00);
    chk("rstd_done", commit_done, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rstd_no_done", commit_done, 1'b0);
    end

    // Three-cluster instance: index 3 is out of range
    n3_cfg_valid = 1'b1; n3_cfg_idx = 2'd2; n3_cfg_sel_end = 1'b0; n3_cfg_addr = 32'h5000;
    tick();
    chk("n3_err_ok_write", n3_err, 1'b0);
    n3_cfg_idx = 2'd3; n3_cfg_sel_end = 1'b1; n3_cfg_addr = 32'hDEAD;
    chk("n3_cfg_ready_bad", n3_cfg_ready, 1'b1);
    tick();
    n3_cfg_valid = 1'b0;
    chk("n3_err_bad_idx", n3_err, 1'b1);
    n3_commit_valid = 1'b1;
    tick();
    n3_commit_valid = 1'b0;
    tick();
    chk("n3_no_early_done", n3_done, 1'b0);
    tick();
    chk("n3_done", n3_done, 1'b1);
    chk("n3_start", n3_start, {32'h5000, 32'h0, 32'h0});
    chk("n3_end", n3_end, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
